// File: rtl/aukv_mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, bus owners, tie policy.
package aukv_mem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int unsigned ARB_RR     = 0;
  localparam int unsigned ARB_D_PRIO = 1;

  function automatic owner_t pick_owner(input int unsigned mode, input logic req_i,
                                        input logic req_d, input owner_t last);
    if (req_i && req_d)
      return (mode == ARB_D_PRIO || last == OWN_I) ? OWN_D : OWN_I;
    return req_d ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/aukv_mem_arb_req_slot.sv
// One requester slot: captures a pulse request while idle and tracks it
// until the arbiter reports completion.
module aukv_req_slot #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdata,
  input  logic [3:0]    i_strobe,
  input  logic          i_grant,
  input  logic          i_done,
  output logic          o_req,
  output logic          o_busy,
  output logic [AW-1:0] o_addr,
  output logic          o_we,
  output logic [DW-1:0] o_wdata,
  output logic [3:0]    o_strobe
);

  logic          pending, inflight, cap;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    strobe_q;

  assign o_busy = pending | inflight;
  assign cap    = i_en & ~o_busy;
  assign o_req  = pending | cap;

  // Fields bypass to the live inputs while not pending so a fresh request
  // can be granted in its own capture cycle.
  assign o_addr   = pending ? addr_q   : i_addr;
  assign o_we     = pending ? we_q     : i_we;
  assign o_wdata  = pending ? wdata_q  : i_wdata;
  assign o_strobe = pending ? strobe_q : i_strobe;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pending  <= 1'b0;
      inflight <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      if (cap) begin
        addr_q   <= i_addr;
        we_q     <= i_we;
        wdata_q  <= i_wdata;
        strobe_q <= i_strobe;
      end
      if (i_grant) begin
        pending  <= 1'b0;
        inflight <= 1'b1;
      end else if (cap) begin
        pending  <= 1'b1;
      end
      if (i_done) inflight <= 1'b0;
    end
  end

endmodule

// File: rtl/aukv_mem_arb.sv
// Shares one single-port memory bus between the fetch (I) and memory-access (D)
// ports, with round-robin or D-priority tie breaking and a WAIT watchdog.
module aukv_mem_arb #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_i_en,
  input  logic [AW-1:0] i_i_addr,
  output logic [DW-1:0] o_i_rdata,
  output logic          o_i_valid,
  output logic          o_i_err,
  output logic          o_i_busy,
  input  logic          i_d_en,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  input  logic [3:0]    i_d_strobe,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_valid,
  output logic          o_d_err,
  output logic          o_d_busy,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic [3:0]    o_mem_strobe,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_mem_valid
);
  import aukv_mem_arb_pkg::*;

  logic          i_req, d_req;
  logic [AW-1:0] i_sel_addr, d_sel_addr;
  logic          i_sel_we, d_sel_we;
  logic [DW-1:0] i_sel_wdata, d_sel_wdata;
  logic [3:0]    i_sel_strobe, d_sel_strobe;
  arb_state_t    state, state_nx;
  owner_t        owner, last_grant, sel;
  logic          grant_i, grant_d, done_ok, done_to, done_i, done_d, to_hit;
  logic [TO_W-1:0] cnt;

  aukv_req_slot #(.AW(AW), .DW(DW)) u_i_slot (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_i_en), .i_addr(i_i_addr),
    .i_we(1'b0), .i_wdata('0), .i_strobe(4'hf),
    .i_grant(grant_i), .i_done(done_i),
    .o_req(i_req), .o_busy(o_i_busy), .o_addr(i_sel_addr), .o_we(i_sel_we),
    .o_wdata(i_sel_wdata), .o_strobe(i_sel_strobe)
  );

  aukv_req_slot #(.AW(AW), .DW(DW)) u_d_slot (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_d_en), .i_addr(i_d_addr),
    .i_we(i_d_we), .i_wdata(i_d_wdata), .i_strobe(i_d_strobe),
    .i_grant(grant_d), .i_done(done_d),
    .o_req(d_req), .o_busy(o_d_busy), .o_addr(d_sel_addr), .o_we(d_sel_we),
    .o_wdata(d_sel_wdata), .o_strobe(d_sel_strobe)
  );

  assign to_hit = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == 32'(TIMEOUT));
  assign done_i = (done_ok | done_to) && (owner == OWN_I);
  assign done_d = (done_ok | done_to) && (owner == OWN_D);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sel      = OWN_I;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          sel      = pick_owner(ARB_MODE, i_req, d_req, last_grant);
          grant_d  = (sel == OWN_D);
          grant_i  = (sel == OWN_I);
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_valid) begin
          done_ok  = 1'b1;
          state_nx = ST_IDLE;
        end else if (to_hit) begin
          done_to  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_en     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_mem_strobe <= '0;
      owner        <= OWN_I;
      last_grant   <= OWN_I;
      cnt          <= '0;
      o_i_valid    <= 1'b0;
      o_i_err      <= 1'b0;
      o_i_rdata    <= '0;
      o_d_valid    <= 1'b0;
      o_d_err      <= 1'b0;
      o_d_rdata    <= '0;
    end else begin
      o_mem_en <= grant_i | grant_d;
      if (grant_i | grant_d) begin
        o_mem_we     <= grant_d ? d_sel_we     : i_sel_we;
        o_mem_addr   <= grant_d ? d_sel_addr   : i_sel_addr;
        o_mem_data   <= grant_d ? d_sel_wdata  : i_sel_wdata;
        o_mem_strobe <= grant_d ? d_sel_strobe : i_sel_strobe;
        owner        <= sel;
        last_grant   <= sel;
      end
      if (state == ST_WAIT && !done_ok && !done_to) cnt <= cnt + 1'b1;
      else                                           cnt <= '0;
      o_i_valid <= done_i;
      o_i_err   <= done_i & done_to;
      if (done_i) o_i_rdata <= done_ok ? i_mem_data : '0;
      o_d_valid <= done_d;
      o_d_err   <= done_d & done_to;
      if (done_d) o_d_rdata <= done_ok ? i_mem_data : '0;
    end
  end

endmodule

// File: tb/tb_aukv_mem_arb.sv
// Scoreboard bench: stimulus pushes planned memory responses and expected port
// completions; a memory responder and a completion monitor check independently.
module tb_aukv_mem_arb;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    int unsigned lat;
    bit          answer;
    bit          late;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic        i_en, i_valid, i_err, i_busy;
  logic [31:0] i_addr, i_rdata;
  logic        d_en, d_we, d_valid, d_err, d_busy;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_strobe;
  logic        m_en, m_we, m_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strobe;

  logic        p_i_en, p_i_valid, p_i_err, p_i_busy;
  logic [31:0] p_i_addr, p_i_rdata;
  logic        p_d_en, p_d_valid, p_d_err, p_d_busy;
  logic [31:0] p_d_addr, p_d_rdata;
  logic        p_m_en, p_m_we, p_m_valid;
  logic [31:0] p_m_addr, p_m_wdata, p_m_rdata;
  logic [3:0]  p_m_strobe;

  aukv_mem_arb #(.AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT(4), .TO_W(8)) u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_i_en(i_en), .i_i_addr(i_addr), .o_i_rdata(i_rdata), .o_i_valid(i_valid),
    .o_i_err(i_err), .o_i_busy(i_busy),
    .i_d_en(d_en), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_strobe(d_strobe), .o_d_rdata(d_rdata), .o_d_valid(d_valid),
    .o_d_err(d_err), .o_d_busy(d_busy),
    .o_mem_en(m_en), .o_mem_we(m_we), .o_mem_addr(m_addr), .o_mem_data(m_wdata),
    .o_mem_strobe(m_strobe), .i_mem_data(m_rdata), .i_mem_valid(m_valid)
  );

  aukv_mem_arb #(.AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT(4), .TO_W(8)) u_dut_prio (
    .i_clk(clk), .i_rstn(rstn),
    .i_i_en(p_i_en), .i_i_addr(p_i_addr), .o_i_rdata(p_i_rdata), .o_i_valid(p_i_valid),
    .o_i_err(p_i_err), .o_i_busy(p_i_busy),
    .i_d_en(p_d_en), .i_d_we(1'b0), .i_d_addr(p_d_addr), .i_d_wdata(32'h0),
    .i_d_strobe(4'hf), .o_d_rdata(p_d_rdata), .o_d_valid(p_d_valid),
    .o_d_err(p_d_err), .o_d_busy(p_d_busy),
    .o_mem_en(p_m_en), .o_mem_we(p_m_we), .o_mem_addr(p_m_addr), .o_mem_data(p_m_wdata),
    .o_mem_strobe(p_m_strobe), .i_mem_data(p_m_rdata), .i_mem_valid(p_m_valid)
  );

  plan_t       plan_i[$], plan_d[$];
  exp_t        exp_i[$], exp_d[$];
  bit          grant_log[$];
  logic [31:0] refmem [logic [31:0]];
  int          tests = 0, fails = 0;
  int          n_i_done = 0, n_d_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten locations read back a deterministic, address-dependent word.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (refmem.exists(a)) return refmem[a];
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic push_i(input logic [31:0] a, input int unsigned lat, input bit ans,
                        input bit late, input bit want);
    plan_t p;
    exp_t  e;
    p.addr = a; p.we = 1'b0; p.wdata = '0; p.strobe = 4'hf;
    p.lat = lat; p.answer = ans; p.late = late; p.rdata = mem_rd(a);
    plan_i.push_back(p);
    e.rdata = ans ? p.rdata : 32'h0;
    e.err   = !ans;
    if (want) exp_i.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] w,
                        input logic [3:0] s, input int unsigned lat, input bit ans,
                        input bit late, input bit want);
    plan_t p;
    exp_t  e;
    p.addr = a; p.we = we; p.wdata = w; p.strobe = s;
    p.lat = lat; p.answer = ans; p.late = late; p.rdata = mem_rd(a);
    plan_d.push_back(p);
    if (ans && we) refmem[a] = merge(p.rdata, w, s);
    e.rdata = ans ? p.rdata : 32'h0;
    e.err   = !ans;
    if (want) exp_d.push_back(e);
  endtask

  // Memory responder: answers each bus request according to its plan entry.
  initial begin : responder
    plan_t p;
    bit    is_d;
    m_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_valid = 1'b0;
      if (rstn && m_en) begin
        if (plan_d.size() != 0 && plan_d[0].addr == m_addr) begin
          is_d = 1'b1; p = plan_d.pop_front();
        end else if (plan_i.size() != 0 && plan_i[0].addr == m_addr) begin
          is_d = 1'b0; p = plan_i.pop_front();
        end else begin
          check("mem_unexpected_req", m_en, 0);
          continue;
        end
        grant_log.push_back(is_d);
        check("mem_we", m_we, p.we);
        check("mem_strobe", m_strobe, p.strobe);
        if (p.we) check("mem_wdata", m_wdata, p.wdata);
        if (p.answer) begin
          repeat (p.lat) @(negedge clk);
          m_valid = 1'b1;
          m_rdata = p.rdata;
        end else if (p.late) begin
          repeat (8) @(negedge clk);
          m_valid = 1'b1;
          m_rdata = 32'hbad0_bad0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (i_valid && d_valid) check("both_valid", i_valid & d_valid, 0);
        if (i_valid) begin
          n_i_done++;
          check("i_busy_at_valid", i_busy, 0);
          if (exp_i.size() == 0) check("i_unexpected_valid", i_valid, 0);
          else begin
            e = exp_i.pop_front();
            check("i_rdata", i_rdata, e.rdata);
            check("i_err", i_err, e.err);
          end
        end
        if (d_valid) begin
          n_d_done++;
          check("d_busy_at_valid", d_busy, 0);
          if (exp_d.size() == 0) check("d_unexpected_valid", d_valid, 0);
          else begin
            e = exp_d.pop_front();
            check("d_rdata", d_rdata, e.rdata);
            check("d_err", d_err, e.err);
          end
        end
      end
    end
  end

  task automatic wait_valid(input bit dport, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(dport ? d_valid : i_valid) && cyc < 40);
    if (!(dport ? d_valid : i_valid)) check("wait_valid_bound", dport ? d_valid : i_valid, 1);
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while ((exp_i.size() != 0 || exp_d.size() != 0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", exp_i.size() + exp_d.size(), 0);
  endtask

  task automatic p_serve(output logic [31:0] a);
    int k = 0;
    a = '1;
    do begin
      @(negedge clk);
      k++;
    end while (!p_m_en && k < 20);
    if (!p_m_en) check("prio_grant_bound", p_m_en, 1);
    else a = p_m_addr;
    p_m_valid = 1'b1;
    p_m_rdata = a;
    @(negedge clk);
    p_m_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          k, n0;
    bit          just_i, just_d, iss;
    logic [31:0] a1, a2;
    i_en = 0; i_addr = '0;
    d_en = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_strobe = '0;
    p_i_en = 0; p_i_addr = '0; p_d_en = 0; p_d_addr = '0;
    p_m_valid = 0; p_m_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_mem_ctl", {m_en, m_we, m_strobe, m_addr}, 0);
    check("rst_mem_data", m_wdata, 0);
    check("rst_flags", {i_valid, i_err, i_busy, d_valid, d_err, d_busy}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single D read
    @(posedge clk); #1;
    refmem[32'h100] = 32'hdead_beef;
    push_d(32'h100, 1'b0, '0, 4'hf, 2, 1, 0, 1);
    d_en = 1; d_addr = 32'h100; d_we = 0; d_strobe = 4'hf;
    @(posedge clk); #1 d_en = 0;
    @(negedge clk);
    check("t1_mem_en", m_en, 1);
    check("t1_mem_addr", m_addr, 32'h100);
    check("t1_d_busy", d_busy, 1);
    wait_valid(1, k);
    check("t1_valid_latency", k, 3);
    wait_drain(10);

    // Same-cycle ties after a fresh reset (last grant = I)
    @(negedge clk); #1 rstn = 1'b0;
    @(negedge clk); #1 rstn = 1'b1;
    grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      push_i(32'h0, $urandom_range(0, 2), 1, 0, 1);
      push_d(32'h200, 1'b0, '0, 4'hf, $urandom_range(0, 2), 1, 0, 1);
      i_en = 1; i_addr = 32'h0; d_en = 1; d_addr = 32'h200; d_we = 0; d_strobe = 4'hf;
      @(posedge clk); #1 i_en = 0; d_en = 0;
      wait_drain(40);
    end
    check("t2_grant_count", grant_log.size(), 6);
    for (int j = 0; j < 6 && j < grant_log.size(); j++)
      check("t2_grant_order", grant_log[j], (j % 2 == 0) ? 1 : 0);

    // D write queued behind an in-flight I read
    @(posedge clk); #1;
    push_i(32'h40, 2, 1, 0, 1);
    i_en = 1; i_addr = 32'h40;
    @(posedge clk); #1 i_en = 0;
    push_d(32'h80, 1'b1, 32'h1234_5678, 4'h3, 1, 1, 0, 1);
    d_en = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_strobe = 4'h3;
    @(posedge clk); #1 d_en = 0; d_we = 0;
    wait_valid(0, k);
    @(negedge clk);
    check("t3_mem_en", m_en, 1);
    check("t3_mem_we", m_we, 1);
    check("t3_mem_strobe", m_strobe, 4'h3);
    check("t3_mem_wdata", m_wdata, 32'h1234_5678);
    check("t3_mem_addr", m_addr, 32'h80);
    wait_drain(20);

    // Watchdog abort, then a late memory answer that must be ignored
    @(posedge clk); #1;
    push_i(32'h44, 0, 0, 1, 1);
    i_en = 1; i_addr = 32'h44;
    @(posedge clk); #1 i_en = 0;
    @(negedge clk);
    check("t4_mem_en", m_en, 1);
    wait_valid(0, k);
    check("t4_timeout_latency", k, 4);
    n0 = n_i_done + n_d_done;
    repeat (12) @(negedge clk);
    check("t4_late_ignored", n_i_done + n_d_done - n0, 0);

    // Second D pulse while busy is dropped
    n0 = n_d_done;
    @(posedge clk); #1;
    push_d(32'h300, 1'b0, '0, 4'hf, 1, 1, 0, 1);
    d_en = 1; d_we = 0; d_addr = 32'h300; d_strobe = 4'hf;
    @(posedge clk); #1 d_addr = 32'h304;
    @(posedge clk); #1 d_en = 0;
    wait_drain(20);
    repeat (4) @(negedge clk);
    check("t5_one_completion", n_d_done - n0, 1);
    check("t5_plan_left", plan_d.size(), 0);

    // Reset while in WAIT
    @(posedge clk); #1;
    push_d(32'h400, 1'b0, '0, 4'hf, 3, 1, 0, 0);
    d_en = 1; d_addr = 32'h400; d_strobe = 4'hf;
    @(posedge clk); #1 d_en = 0;
    @(negedge clk);
    check("t6_mem_en", m_en, 1);
    @(negedge clk); #1 rstn = 1'b0;
    #1;
    check("t6_rst_mem_ctl", {m_en, m_we, m_strobe, m_addr}, 0);
    check("t6_rst_flags", {i_valid, i_err, i_busy, d_valid, d_err, d_busy}, 0);
    check("t6_rst_rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk); #1 rstn = 1'b1;
    n0 = n_i_done + n_d_done;
    repeat (6) @(negedge clk);
    check("t6_no_pulse", n_i_done + n_d_done - n0, 0);
    check("t6_plan_left", plan_d.size(), 0);
    @(posedge clk); #1;
    push_d(32'h404, 1'b0, '0, 4'hf, 1, 1, 0, 1);
    d_en = 1; d_addr = 32'h404;
    @(posedge clk); #1 d_en = 0;
    wait_drain(20);

    // Randomized traffic
    just_i = 0; just_d = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      i_en = 0; d_en = 0;
      iss = 0;
      if (just_i) begin
        if ($urandom_range(0, 3) == 0) begin i_en = 1; i_addr = 32'h1000 + 4 * $urandom_range(0, 15); end
      end else if (exp_i.size() == 0 && $urandom_range(0, 2) == 0) begin
        i_addr = 32'h1000 + 4 * $urandom_range(0, 15);
        push_i(i_addr, $urandom_range(0, 2), $urandom_range(0, 9) != 0, 0, 1);
        i_en = 1; iss = 1;
      end
      just_i = iss;
      iss = 0;
      if (just_d) begin
        if ($urandom_range(0, 3) == 0) begin
          d_en = 1; d_we = 1'($urandom); d_addr = 32'h2000 + 4 * $urandom_range(0, 7);
          d_wdata = $urandom; d_strobe = 4'($urandom_range(1, 15));
        end
      end else if (exp_d.size() == 0 && $urandom_range(0, 2) == 0) begin
        d_we = 1'($urandom); d_addr = 32'h2000 + 4 * $urandom_range(0, 7);
        d_wdata = $urandom; d_strobe = 4'($urandom_range(1, 15));
        push_d(d_addr, d_we, d_wdata, d_strobe, $urandom_range(0, 2),
               $urandom_range(0, 9) != 0, 0, 1);
        d_en = 1; iss = 1;
      end
      just_d = iss;
    end
    @(posedge clk); #1 i_en = 0; d_en = 0;
    wait_drain(100);
    repeat (4) @(negedge clk);
    check("rand_plans_left", plan_i.size() + plan_d.size(), 0);

    // Fixed D priority instance: D wins ties even right after a D grant
    @(posedge clk); #1 p_d_en = 1; p_d_addr = 32'h500;
    @(posedge clk); #1 p_d_en = 0;
    p_serve(a1);
    check("prio_lone_d", a1, 32'h500);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      p_i_en = 1; p_i_addr = 32'h0; p_d_en = 1; p_d_addr = 32'h200;
      @(posedge clk); #1 p_i_en = 0; p_d_en = 0;
      p_serve(a1);
      p_serve(a2);
      check("prio_tie_first", a1, 32'h200);
      check("prio_tie_second", a2, 32'h0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
